// File: rtl/inst_reg.sv
// Instruction register: captures a bus word on command and returns its operand
// field to the shared bus through a tri-state driver.
module inst_reg #(
    parameter int WIDTH     = 8,
    parameter int OUT_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic [WIDTH-1:0]     busin,
    input  logic                 wa,
    input  logic                 oa,
    output logic [OUT_WIDTH-1:0] instout
);

    logic [WIDTH-1:0] ir_reg;
    logic [WIDTH-1:0] ir_next;

    always_comb begin
        ir_next = ir_reg;
        if (wa) begin
            ir_next = busin;
        end
    end

    // Clear wins over a simultaneous write.
    always_ff @(posedge clk) begin
        if (!clr) begin
            ir_reg <= '0;
        end else begin
            ir_reg <= ir_next;
        end
    end

    // Opcode bits above OUT_WIDTH stay internal; only the operand reaches the bus.
    generate
        for (genvar gi = 0; gi < OUT_WIDTH; gi++) begin : g_out
            assign instout[gi] = oa ? ir_reg[gi] : 1'bz;
        end
    endgenerate

endmodule

// File: tb/tb_inst_reg.sv
// Self-checking bench for inst_reg: directed cases plus randomized cycles
// against a one-register reference model.
module tb_inst_reg;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       wa = 1'b0;
    logic       oa = 1'b0;
    logic [7:0] busin = 8'h00;
    wire  [3:0] instout;

    // A second weak-role driver on the bus: when the DUT should be released,
    // the bench drives a known pattern and expects to read it back intact.
    logic       probe_en = 1'b0;
    logic [3:0] probe_val = 4'h0;
    assign instout = probe_en ? probe_val : 4'bzzzz;

    int errors = 0;
    int checks = 0;
    int probe_cnt = 0;
    logic [7:0] ref_ir = 8'h00;

    inst_reg #(.WIDTH(8), .OUT_WIDTH(4)) dut (
        .clk(clk),
        .clr(clr),
        .busin(busin),
        .wa(wa),
        .oa(oa),
        .instout(instout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Expect released bus when exp_z, else the given operand nibble.
    task automatic observe(input string tag, input bit exp_z, input logic [3:0] exp_nib);
        if (exp_z) begin
            probe_val = (probe_cnt % 2 == 0) ? 4'h5 : 4'hA;
            probe_cnt++;
            probe_en = 1'b1;
            #1;
            check(tag, instout, probe_val);
            probe_en = 1'b0;
        end else begin
            probe_en = 1'b0;
            #1;
            check(tag, instout, exp_nib);
        end
    endtask

    // One clock transaction: b is presented first, b_mid replaces it mid-cycle.
    task automatic step(input bit c, input bit w, input bit o,
                        input logic [7:0] b, input logic [7:0] b_mid,
                        input logic [3:0] exp_pre, input logic [3:0] exp_post,
                        input string tag);
        @(negedge clk);
        clr = c; wa = w; oa = o; busin = b;
        observe({tag, "/pre"}, !o, exp_pre);
        busin = b_mid;
        @(posedge clk);
        if (!c)     ref_ir = 8'h00;
        else if (w) ref_ir = busin;
        #1;
        observe({tag, "/post"}, !o, exp_post);
        $display("txn %-10s clr=%0b wa=%0b oa=%0b bus=%h/%h instout=%h", tag, c, w, o, b, b_mid, instout);
    endtask

    initial begin
        logic [7:0] nb;
        logic [7:0] nb2;
        logic [7:0] nxt;
        bit rc;
        bit rw;
        bit ro;

        // Directed cases
        step(1'b0, 1'b0, 1'b0, 8'h78, 8'h78, 4'h0, 4'h0, "rst");
        step(1'b1, 1'b0, 1'b1, 8'h78, 8'h78, 4'h0, 4'h0, "rst_oa");
        step(1'b1, 1'b1, 1'b0, 8'h78, 8'h78, 4'h0, 4'h0, "load");
        step(1'b1, 1'b0, 1'b1, 8'h78, 8'h78, 4'h8, 4'h8, "load_out");
        step(1'b1, 1'b0, 1'b1, 8'h29, 8'h29, 4'h8, 4'h8, "hold_bus");
        step(1'b1, 1'b1, 1'b0, 8'h29, 8'h29, 4'h0, 4'h0, "reload");
        step(1'b1, 1'b0, 1'b1, 8'h29, 8'h29, 4'h9, 4'h9, "reload_out");
        step(1'b0, 1'b1, 1'b1, 8'hFF, 8'hFF, 4'h9, 4'h0, "rst_pri");
        step(1'b1, 1'b1, 1'b0, 8'h78, 8'h78, 4'h0, 4'h0, "set78");
        step(1'b1, 1'b1, 1'b1, 8'h2A, 8'h2A, 4'h8, 4'hA, "wr_out");
        step(1'b1, 1'b1, 1'b1, 8'h33, 8'hC4, 4'hA, 4'h4, "mid_bus");
        step(1'b1, 1'b0, 1'b0, 8'h11, 8'hE7, 4'h4, 4'h4, "hold0");
        step(1'b1, 1'b0, 1'b1, 8'h3B, 8'h90, 4'h4, 4'h4, "hold1");
        step(1'b1, 1'b0, 1'b0, 8'hD2, 8'h6F, 4'h4, 4'h4, "hold2");
        step(1'b1, 1'b0, 1'b1, 8'hA5, 8'h0C, 4'h4, 4'h4, "hold3");

        // Randomized cycles against the reference register
        for (int i = 0; i < 200; i++) begin
            rc  = ($urandom_range(0, 7) != 0);
            rw  = $urandom_range(0, 1) == 1;
            ro  = $urandom_range(0, 1) == 1;
            nb  = 8'($urandom);
            nb2 = ($urandom_range(0, 1) == 1) ? 8'($urandom) : nb;
            if (!rc)     nxt = 8'h00;
            else if (rw) nxt = nb2;
            else         nxt = ref_ir;
            step(rc, rw, ro, nb, nb2, ref_ir[3:0], nxt[3:0], "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
